led_sequencer: RTL and testbench

Sequencing controller for the 10-LED one-hot decoder on the board. It accepts a one-shot command (mode plus target LED), steps a 4-bit LED index through a chase, bounce, flash or spin pattern at a programmable step rate, and signals completion. `number` feeds the decoder's 4-bit input directly. Blanking uses code 4'd15, which the decoder maps to all LEDs off.

---
 rtl/led_sequencer.sv | 124 ++++++++++++
 tb/tb_led_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps a 4-bit decoder index through chase, bounce,
// flash or spin patterns at a programmable rate and pulses done on completion.
module led_sequencer #(
    parameter int TICK_DIV    = 12_500_000,
    parameter int FLASH_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic [3:0] target,
    output logic [3:0] number,
    output logic       busy,
    output logic       done
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [4:0]    FLASH_LAST = 5'(2 * FLASH_COUNT - 1);
    localparam logic [3:0]    BLANK      = 4'd15;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    target_q, target_d;
    logic [4:0]    step_q, step_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    number_q, number_d;
    logic          done_q, done_d;
    logic [3:0]    target_clamped;

    // Display value for a given step of a pattern.
    function automatic logic [3:0] seq_val(input logic [1:0] md, input logic [4:0] st,
                                           input logic [3:0] tg);
        logic [4:0] v;
        case (md)
            2'd0:    v = st;
            2'd1:    v = (st <= 5'd9) ? st : 5'd18 - st;
            2'd2:    v = st[0] ? {1'b0, BLANK} : {1'b0, tg};
            default: v = (st <= 5'd9) ? st : st - 5'd10;
        endcase
        return v[3:0];
    endfunction

    function automatic logic [4:0] last_step(input logic [1:0] md, input logic [3:0] tg);
        case (md)
            2'd0:    return 5'd9;
            2'd1:    return 5'd18;
            2'd2:    return FLASH_LAST;
            default: return 5'd10 + {1'b0, tg};
        endcase
    endfunction

    assign target_clamped = (target > 4'd9) ? 4'd9 : target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            target_q <= 4'd0;
            step_q   <= 5'd0;
            tick_q   <= '0;
            number_q <= BLANK;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            number_q <= number_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        step_d   = step_q;
        tick_d   = tick_q;
        number_d = number_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    target_d = target_clamped;
                    step_d   = 5'd0;
                    tick_d   = '0;
                    number_d = seq_val(mode, 5'd0, target_clamped);
                end
            end
            default: begin
                // Abort wins over a coincident step tick or completion.
                if (abort) begin
                    state_d  = IDLE;
                    step_d   = 5'd0;
                    tick_d   = '0;
                    number_d = BLANK;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (step_q == last_step(mode_q, target_q)) begin
                        state_d  = IDLE;
                        step_d   = 5'd0;
                        number_d = BLANK;
                        done_d   = 1'b1;
                    end else begin
                        step_d   = step_q + 5'd1;
                        number_d = seq_val(mode_q, step_q + 5'd1, target_q);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
        endcase
    end

    assign number = number_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: table-driven patterns, hand-written
// corner sequences and random stimulus against a queue-based reference model.
module tb_led_sequencer;
    localparam int TD = 4;
    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] mode;
    logic [3:0] target;
    logic [3:0] number;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    // Model: one queue entry per remaining cycle of the run, holding the shown value.
    int q[$];
    bit m_done;

    always #5 clk = ~clk;

    led_sequencer #(.TICK_DIV(TD), .FLASH_COUNT(FC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .target(target), .number(number), .busy(busy), .done(done)
    );

    typedef struct {
        int md;
        int tg;
        int done_edge;
        int first_val;
        int last_val;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void build(input int md, input int tg);
        int vals[$];
        int t;
        t = (tg > 9) ? 9 : tg;
        case (md)
            0: for (int i = 0; i <= 9; i++) vals.push_back(i);
            1: begin
                for (int i = 0; i <= 9; i++) vals.push_back(i);
                for (int i = 8; i >= 0; i--) vals.push_back(i);
            end
            2: for (int i = 0; i < FC; i++) begin
                vals.push_back(t);
                vals.push_back(15);
            end
            default: begin
                for (int i = 0; i <= 9; i++) vals.push_back(i);
                for (int i = 0; i <= t; i++) vals.push_back(i);
            end
        endcase
        foreach (vals[i]) for (int k = 0; k < TD; k++) q.push_back(vals[i]);
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (rst) q.delete();
        else if (q.size() > 0) begin
            if (abort) q.delete();
            else begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (start) build(int'(mode), int'(target));
        chk({tag, "_number"}, 32'(number), (q.size() > 0) ? 32'(q[0]) : 32'd15);
        chk({tag, "_busy"}, 32'(busy), 32'(q.size() > 0));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
    endtask

    task automatic begin_run(input int md, input int tg, input string tag);
        start = 1'b1; mode = 2'(md); target = 4'(tg);
        tick(tag);
        start = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        bit   saw_done;
        vecs[0] = '{0, 0,  40, 0, 9};
        vecs[1] = '{1, 0,  76, 0, 0};
        vecs[2] = '{3, 3,  56, 0, 3};
        vecs[3] = '{3, 12, 80, 0, 9};
        vecs[4] = '{2, 5,  24, 5, 15};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; target = 4'd0;
        tick("reset");
        tick("reset");
        chk("reset_number", 32'(number), 32'd15);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick("idle");

        foreach (vecs[v]) begin
            begin_run(vecs[v].md, vecs[v].tg, "tbl");
            chk("tbl_first", 32'(number), 32'(vecs[v].first_val));
            chk("tbl_busy_on", 32'(busy), 32'd1);
            for (int e = 1; e <= vecs[v].done_edge + 2; e++) begin
                tick("tbl");
                if (e == vecs[v].done_edge - 1) chk("tbl_last", 32'(number), 32'(vecs[v].last_val));
                if (e == vecs[v].done_edge) begin
                    chk("tbl_done_edge", 32'(done), 32'd1);
                    chk("tbl_end_busy", 32'(busy), 32'd0);
                    chk("tbl_end_number", 32'(number), 32'd15);
                end
            end
        end

        // Reset three cycles in the middle of a bounce.
        begin_run(1, 0, "rstmid");
        for (int e = 1; e < 20; e++) tick("rstmid");
        rst = 1'b1;
        saw_done = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick("rstmid_rst");
            saw_done |= done;
        end
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick("rstmid_after");
            saw_done |= done;
        end
        chk("rstmid_no_done", 32'(saw_done), 32'd0);
        chk("rstmid_idle", 32'(busy), 32'd0);

        // Aborts at edge 10, the edge before completion and the completion edge itself.
        foreach (vecs[a]) begin
            int ae;
            if (a > 2) break;
            ae = (a == 0) ? 10 : (a == 1) ? 39 : 40;
            begin_run(0, 0, "abort");
            for (int e = 1; e < ae; e++) tick("abort");
            abort = 1'b1;
            tick("abort_edge");
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_number", 32'(number), 32'd15);
            chk("abort_no_done", 32'(done), 32'd0);
            saw_done = 1'b0;
            for (int e = 0; e < 45; e++) begin
                tick("abort_after");
                saw_done |= done;
            end
            chk("abort_never_done", 32'(saw_done), 32'd0);
        end

        // Start strobes during a run are ignored.
        begin_run(0, 0, "busystart");
        for (int e = 1; e <= 42; e++) begin
            start = (e == 5 || e == 20);
            mode  = 2'd1;
            tick("busystart");
            start = 1'b0;
            if (e == 40) chk("busystart_done40", 32'(done), 32'd1);
        end

        // Start held through the done cycle re-launches after one blank cycle.
        start = 1'b1; mode = 2'd0; target = 4'd0;
        tick("held");
        for (int e = 1; e <= 83; e++) begin
            if (e == 42) start = 1'b0;
            tick("held");
            if (e == 40) chk("held_done1", 32'(done), 32'd1);
            if (e == 41) chk("held_restart", 32'(busy), 32'd1);
            if (e == 81) chk("held_done2", 32'(done), 32'd1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            start  = ($urandom_range(0, 5) == 0);
            abort  = ($urandom_range(0, 59) == 0);
            mode   = 2'($urandom_range(0, 3));
            target = 4'($urandom_range(0, 15));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
